wb_write_arbiter: RTL and testbench

//   Writeback-side driver of the register file write port (we/destReg/writeData).

---
 rtl/wb_write_arbiter.sv | 112 +++++++++++
 tb/tb_wb_write_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges ALU results and queued load results into one registered regfile write per cycle.
// Latency: ALU result 1 cycle, load result 2 cycles minimum (push, then pop into the output registers).
// Backpressure: ld_ready_po low only when the load queue is full; alu_ready_po low whenever a load pops instead.
// Optional macro WB_X0_FILTER_EN: results targeting x0 are consumed without asserting we_po.
module wb_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LQ_DEPTH = 4
) (
    input  logic                          clk_pi,
    input  logic                          reset_pi,
    input  logic                          alu_valid_pi,
    input  logic [ADDR_W-1:0]             alu_rd_pi,
    input  logic [DATA_W-1:0]             alu_data_pi,
    output logic                          alu_ready_po,
    input  logic                          ld_valid_pi,
    input  logic [ADDR_W-1:0]             ld_rd_pi,
    input  logic [DATA_W-1:0]             ld_data_pi,
    output logic                          ld_ready_po,
    output logic                          we_po,
    output logic [ADDR_W-1:0]             destReg_po,
    output logic [DATA_W-1:0]             writeData_po,
    output logic [$clog2(LQ_DEPTH):0]     lq_count_po
);

    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + DATA_W;

    // Load queue storage: {rd, data} per entry
    logic [EW-1:0]     lq_mem_q [LQ_DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Registered regfile write port
    logic              we_q, we_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              lq_empty, lq_full;
    logic              pop, push, alu_take;
    logic [EW-1:0]     head;
    logic              sel_vld, issue;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    // Select between queue head and ALU, and compute next state for pointers and outputs
    always_comb begin
        lq_empty = (cnt_q == '0);
        lq_full  = (cnt_q == CW'(LQ_DEPTH));
        // A load drains when the ALU is idle, or forcibly when the queue is full
        pop      = !lq_empty && (lq_full || !alu_valid_pi);
        alu_take = alu_valid_pi && !pop;
        // Ready comes only from the registered count, so a pop never frees a slot for the same edge
        push     = ld_valid_pi && !lq_full;

        head     = lq_mem_q[rd_ptr_q];
        sel_vld  = pop || alu_take;
        sel_rd   = pop ? head[EW-1:DATA_W] : alu_rd_pi;
        sel_data = pop ? head[DATA_W-1:0]  : alu_data_pi;

`ifdef WB_X0_FILTER_EN
        // x0 results are consumed but never written
        issue    = sel_vld && (sel_rd != '0);
`else
        issue    = sel_vld;
`endif

        we_d     = issue;
        dest_d   = issue ? sel_rd   : dest_q;
        data_d   = issue ? sel_data : data_q;

        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        cnt_d    = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end

    // Control state and output registers, cleared by synchronous reset
    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            we_q     <= 1'b0;
            dest_q   <= '0;
            data_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            we_q     <= we_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Queue payload; stale contents are harmless because the count gates every read
    always_ff @(posedge clk_pi) begin
        if (push && !reset_pi) begin
            lq_mem_q[wr_ptr_q] <= {ld_rd_pi, ld_data_pi};
        end
    end

    assign alu_ready_po = !pop;
    assign ld_ready_po  = !lq_full;
    assign we_po        = we_q;
    assign destReg_po   = dest_q;
    assign writeData_po = data_q;
    assign lq_count_po  = cnt_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: reset, ALU path, load path, contention, wrap, mid-stream reset, x0 handling.
// Inputs are driven 1 time unit after the rising edge; registered outputs are sampled there too, comb readies at the falling edge.
// Prints one summary line with comparison and mismatch counts.
module tb_wb_write_arbiter;

    logic        clk_pi = 1'b0;
    logic        reset_pi;
    logic        alu_valid_pi;
    logic [4:0]  alu_rd_pi;
    logic [31:0] alu_data_pi;
    logic        alu_ready_po;
    logic        ld_valid_pi;
    logic [4:0]  ld_rd_pi;
    logic [31:0] ld_data_pi;
    logic        ld_ready_po;
    logic        we_po;
    logic [4:0]  destReg_po;
    logic [31:0] writeData_po;
    logic [2:0]  lq_count_po;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] obs[$];
    int          cnt_hist[64];
    int          full_cycles;

    always #5 clk_pi = ~clk_pi;

    wb_write_arbiter #(.DATA_W(32), .ADDR_W(5), .LQ_DEPTH(4)) dut (
        .clk_pi       (clk_pi),
        .reset_pi     (reset_pi),
        .alu_valid_pi (alu_valid_pi),
        .alu_rd_pi    (alu_rd_pi),
        .alu_data_pi  (alu_data_pi),
        .alu_ready_po (alu_ready_po),
        .ld_valid_pi  (ld_valid_pi),
        .ld_rd_pi     (ld_rd_pi),
        .ld_data_pi   (ld_data_pi),
        .ld_ready_po  (ld_ready_po),
        .we_po        (we_po),
        .destReg_po   (destReg_po),
        .writeData_po (writeData_po),
        .lq_count_po  (lq_count_po)
    );

    task automatic tick();
        @(posedge clk_pi);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid_pi = 1'b0;
        alu_rd_pi    = '0;
        alu_data_pi  = '0;
        ld_valid_pi  = 1'b0;
        ld_rd_pi     = '0;
        ld_data_pi   = '0;
    endtask

    // Producer model: n_alu ALU results and n_ld loads, each held until accepted.
    // Records every written data word and the queue count after each edge.
    task automatic run_stream(input int n_alu, input int n_ld, input logic [31:0] alu_base,
                              input logic [31:0] ld_base, input int cycles);
        int ai = 0;
        int lj = 0;
        logic af, lf;
        obs.delete();
        full_cycles = 0;
        for (int c = 0; c < cycles; c++) begin
            alu_valid_pi = (ai < n_alu);
            alu_rd_pi    = 5'(1 + ai);
            alu_data_pi  = alu_base + 32'(ai);
            ld_valid_pi  = (lj < n_ld);
            ld_rd_pi     = 5'(16 + lj);
            ld_data_pi   = ld_base + 32'(lj);
            @(negedge clk_pi);
            af = alu_valid_pi && alu_ready_po;
            lf = ld_valid_pi && ld_ready_po;
            if (lq_count_po == 3'd4) begin
                full_cycles++;
                n_cmp++;
                if (ld_ready_po !== 1'b0 || alu_ready_po !== 1'b0) begin
                    n_bad++;
                    $display("FAIL full_ready: ld_ready=%b alu_ready=%b required 0/0", ld_ready_po, alu_ready_po);
                end
            end
            tick();
            if (we_po === 1'b1) obs.push_back(writeData_po);
            cnt_hist[c] = int'(lq_count_po);
            if (af) ai++;
            if (lf) lj++;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_pi = 1'b1;
        tick();
        tick();
        reset_pi = 1'b0;
        #1;
        n_cmp++;
        if ({we_po, destReg_po, writeData_po, lq_count_po} !== 41'd0) begin
            n_bad++;
            $display("FAIL reset_state: we=%b dest=%0d data=%h cnt=%0d required all 0", we_po, destReg_po, writeData_po, lq_count_po);
        end
        n_cmp++;
        if (alu_ready_po !== 1'b1 || ld_ready_po !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: alu=%b ld=%b required 1/1", alu_ready_po, ld_ready_po);
        end
    endtask

    task automatic test_alu_only();
        alu_valid_pi = 1'b1;
        alu_rd_pi    = 5'd5;
        alu_data_pi  = 32'h1234;
        tick();
        idle_inputs();
        n_cmp++;
        if (we_po !== 1'b1 || destReg_po !== 5'd5 || writeData_po !== 32'h1234) begin
            n_bad++;
            $display("FAIL alu_write: we=%b dest=%0d data=%h required 1/5/00001234", we_po, destReg_po, writeData_po);
        end
        tick();
        n_cmp++;
        if (we_po !== 1'b0 || destReg_po !== 5'd5 || writeData_po !== 32'h1234) begin
            n_bad++;
            $display("FAIL alu_after: we=%b dest=%0d data=%h required 0/5/00001234", we_po, destReg_po, writeData_po);
        end
    endtask

    task automatic test_load_only();
        ld_valid_pi = 1'b1;
        ld_rd_pi    = 5'd7;
        ld_data_pi  = 32'hDEADBEEF;
        tick();
        idle_inputs();
        n_cmp++;
        if (lq_count_po !== 3'd1 || we_po !== 1'b0) begin
            n_bad++;
            $display("FAIL load_push: cnt=%0d we=%b required 1/0", lq_count_po, we_po);
        end
        tick();
        n_cmp++;
        if (we_po !== 1'b1 || destReg_po !== 5'd7 || writeData_po !== 32'hDEADBEEF || lq_count_po !== 3'd0) begin
            n_bad++;
            $display("FAIL load_write: we=%b dest=%0d data=%h cnt=%0d required 1/7/deadbeef/0", we_po, destReg_po, writeData_po, lq_count_po);
        end
        tick();
        n_cmp++;
        if (we_po !== 1'b0) begin
            n_bad++;
            $display("FAIL load_single: we=%b required 0", we_po);
        end
    endtask

    task automatic test_contention();
        logic [31:0] exp_seq [11];
        exp_seq = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hB0, 32'hC4, 32'hB1, 32'hC5, 32'hB2, 32'hB3, 32'hB4};
        run_stream(6, 5, 32'hC0, 32'hB0, 20);
        n_cmp++;
        if (full_cycles != 2) begin
            n_bad++;
            $display("FAIL contention_full_cycles: got %0d required 2", full_cycles);
        end
        n_cmp++;
        if (obs.size() != 11) begin
            n_bad++;
            $display("FAIL contention_count: got %0d writes required 11", obs.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                n_cmp++;
                if (obs[i] !== exp_seq[i]) begin
                    n_bad++;
                    $display("FAIL contention_order[%0d]: got %h required %h", i, obs[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [31:0] exp_seq [10];
        exp_seq = '{32'h50, 32'h51, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7};
        run_stream(2, 8, 32'h50, 32'hA0, 14);
        for (int c = 1; c <= 7; c++) begin
            n_cmp++;
            if (cnt_hist[c] != 2) begin
                n_bad++;
                $display("FAIL wrap_count[%0d]: got %0d required 2", c, cnt_hist[c]);
            end
        end
        n_cmp++;
        if (obs.size() != 10) begin
            n_bad++;
            $display("FAIL wrap_writes: got %0d required 10", obs.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_cmp++;
                if (obs[i] !== exp_seq[i]) begin
                    n_bad++;
                    $display("FAIL wrap_order[%0d]: got %h required %h", i, obs[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        int stray = 0;
        // Three cycles of ALU + load: ALU retires each cycle, queue fills to 3
        for (int i = 0; i < 3; i++) begin
            alu_valid_pi = 1'b1;
            alu_rd_pi    = 5'(2 + i);
            alu_data_pi  = 32'h70 + 32'(i);
            ld_valid_pi  = 1'b1;
            ld_rd_pi     = 5'(20 + i);
            ld_data_pi   = 32'hE0 + 32'(i);
            tick();
        end
        idle_inputs();
        n_cmp++;
        if (lq_count_po !== 3'd3 || we_po !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_setup: cnt=%0d we=%b required 3/1", lq_count_po, we_po);
        end
        reset_pi = 1'b1;
        tick();
        reset_pi = 1'b0;
        n_cmp++;
        if ({we_po, destReg_po, writeData_po, lq_count_po} !== 41'd0) begin
            n_bad++;
            $display("FAIL midrst_state: we=%b dest=%0d data=%h cnt=%0d required all 0", we_po, destReg_po, writeData_po, lq_count_po);
        end
        n_cmp++;
        if (alu_ready_po !== 1'b1 || ld_ready_po !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_ready: alu=%b ld=%b required 1/1", alu_ready_po, ld_ready_po);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (we_po !== 1'b0) stray++;
        end
        n_cmp++;
        if (stray != 0) begin
            n_bad++;
            $display("FAIL midrst_stale: got %0d writes required 0", stray);
        end
    endtask

    task automatic test_x0();
        logic        exp_we;
        logic [4:0]  exp_dest;
        logic [31:0] exp_data;
        alu_valid_pi = 1'b1;
        alu_rd_pi    = 5'd3;
        alu_data_pi  = 32'h33;
        tick();
        alu_rd_pi    = 5'd0;
        alu_data_pi  = 32'hFF;
        #1;
        n_cmp++;
        if (alu_ready_po !== 1'b1) begin
            n_bad++;
            $display("FAIL x0_ready: got %b required 1", alu_ready_po);
        end
        tick();
        idle_inputs();
`ifdef WB_X0_FILTER_EN
        exp_we   = 1'b0;
        exp_dest = 5'd3;
        exp_data = 32'h33;
`else
        exp_we   = 1'b1;
        exp_dest = 5'd0;
        exp_data = 32'hFF;
`endif
        n_cmp++;
        if (we_po !== exp_we || destReg_po !== exp_dest || writeData_po !== exp_data) begin
            n_bad++;
            $display("FAIL x0_write: we=%b dest=%0d data=%h required %b/%0d/%h", we_po, destReg_po, writeData_po, exp_we, exp_dest, exp_data);
        end
    endtask

    initial begin
        reset_pi = 1'b1;
        idle_inputs();
        test_reset();
        test_alu_only();
        test_load_only();
        test_contention();
        test_back_to_back_wrap();
        test_reset_midstream();
        test_x0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
